// File: rtl/kth_noc_axil_pkg.sv
// -----------------------------------------------------------------------------
// kth_noc_axil_pkg
// Shared constants for the AXI4-Lite responder that fronts one 2D-NoC node.
//   RESP_*     : AXI response encodings used on BRESP/RRESP
//   REG_IDX_*  : word indices (ADDR[3:2]) of the four software registers
//   NUM_REGS   : number of software registers
//   resp_t / reg_idx_t : narrow typedefs for responses and register indices
// -----------------------------------------------------------------------------
package kth_noc_axil_pkg;

    typedef logic [1:0] resp_t;
    typedef logic [1:0] reg_idx_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // Word indices of the register file (byte address = index * 4)
    localparam reg_idx_t REG_IDX_DATA0  = 2'd0;  // flit payload
    localparam reg_idx_t REG_IDX_DEST   = 2'd1;  // flit destination in low bits
    localparam reg_idx_t REG_IDX_USER   = 2'd2;  // general purpose scratch
    localparam reg_idx_t REG_IDX_LAUNCH = 2'd3;  // writing here launches a flit

    localparam int NUM_REGS = 4;

endpackage : kth_noc_axil_pkg

// File: rtl/kth_noc_axil_if.sv
// -----------------------------------------------------------------------------
// kth_noc_axil_if
// AXI4-Lite bus bundle between the PS interconnect and the NoC node responder.
// Parameters:
//   C_S_AXI_DATA_WIDTH : data width (32 only)
//   C_S_AXI_ADDR_WIDTH : byte address width (4)
// Modports:
//   slave  : the responder side (kth_noc_axil_slave)
//   master : the requester side (PS interconnect / testbench)
// Clock and reset are not part of the bundle; they stay plain module ports.
// -----------------------------------------------------------------------------
interface kth_noc_axil_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    // write address channel
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                        S_AXI_AWPROT;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    // write data channel
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    // write response channel
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    // read address channel
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                        S_AXI_ARPROT;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    // read data channel
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface : kth_noc_axil_if

// File: rtl/kth_noc_axil_tx_launch.sv
// -----------------------------------------------------------------------------
// kth_noc_axil_tx_launch
// Holds one flit offered to the router local injection port.
// A launch pulse captures payload and destination and raises valid; the
// captured values stay frozen until the router takes the flit (valid&ready),
// after which valid drops on the following cycle.
// Ports:
//   clk, srst  : clock, synchronous active-high reset (discards a pending flit)
//   launch_i   : one-cycle request to capture flit_i/dest_i and raise valid
//   flit_i     : payload to capture
//   dest_i     : destination to capture
//   ready_i    : router ready
//   flit_o     : captured payload
//   dest_o     : captured destination
//   valid_o    : flit offered to the router
//   busy_o     : a flit is pending; further launches must be refused upstream
// -----------------------------------------------------------------------------
module kth_noc_axil_tx_launch #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 2
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              launch_i,
    input  logic [DATA_W-1:0] flit_i,
    input  logic [DEST_W-1:0] dest_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] flit_o,
    output logic [DEST_W-1:0] dest_o,
    output logic              valid_o,
    output logic              busy_o
);

    logic [DATA_W-1:0] flit_reg;
    logic [DEST_W-1:0] dest_reg;
    logic              valid_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_reg <= 1'b0;
            flit_reg  <= '0;
            dest_reg  <= '0;
        end else if (launch_i && !valid_reg) begin
            // Capture only when idle so an in-flight flit is never overwritten
            valid_reg <= 1'b1;
            flit_reg  <= flit_i;
            dest_reg  <= dest_i;
        end else if (valid_reg && ready_i) begin
            valid_reg <= 1'b0;
        end
    end

    assign flit_o  = flit_reg;
    assign dest_o  = dest_reg;
    assign valid_o = valid_reg;
    assign busy_o  = valid_reg;

endmodule : kth_noc_axil_tx_launch

// File: rtl/kth_noc_axil_slave.sv
// -----------------------------------------------------------------------------
// kth_noc_axil_slave
// AXI4-Lite responder giving the processing system access to one 2D-NoC node.
// Four 32-bit read/write registers at byte offsets 0x0/0x4/0x8/0xC:
//   0x0 DATA0  : flit payload
//   0x4 DEST   : flit destination in bits [DEST_W-1:0]
//   0x8 USER   : scratch
//   0xC LAUNCH : a write stores WDATA and launches {DATA0, DEST} into the
//                router local port. While a flit is still pending the write
//                is refused (REG3 untouched) and answered with SLVERR.
// Ports:
//   S_AXI_ACLK     : clock, rising edge
//   S_AXI_ARESET   : synchronous active-high reset
//   s_axi          : AXI4-Lite bundle (kth_noc_axil_if.slave)
//   tx_flit_o      : captured flit payload
//   tx_dest_o      : captured flit destination
//   tx_valid_o     : flit offered to the router
//   tx_ready_i     : router accepts the flit when valid & ready
// Configuration macro:
//   KTH_NOC_AXIL_WSTRB_EN : when defined, only byte lanes with WSTRB[i]=1 are
//                           written; otherwise WSTRB is ignored and every
//                           accepted write replaces all 32 bits.
// -----------------------------------------------------------------------------
module kth_noc_axil_slave
    import kth_noc_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int DEST_W             = 2
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESET,
    kth_noc_axil_if.slave      s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] tx_flit_o,
    output logic [DEST_W-1:0]  tx_dest_o,
    output logic               tx_valid_o,
    input  logic               tx_ready_i
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    logic clk;
    logic srst;
    assign clk  = S_AXI_ACLK;
    assign srst = S_AXI_ARESET;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DW-1:0] regs_reg [NUM_REGS];

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic                          wr_accept_reg;   // drives AWREADY and WREADY
    logic                          bvalid_reg;
    resp_t                         bresp_reg;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
    reg_idx_t                      wr_idx;
    logic                          wr_fire;
    logic                          launch_req;
    logic                          launch_ok;
    logic                          launch_reject;
    logic                          reg_we;
    logic [DW-1:0]                 wr_old;
    logic [DW-1:0]                 wr_word;
    logic                          tx_busy;

    assign aw_addr = s_axi.S_AXI_AWADDR;
    assign wr_idx  = aw_addr[3:2];

    // AW and W are only ever accepted as a pair, so one handshake covers both
    assign wr_fire = wr_accept_reg && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;

    assign launch_req    = wr_fire && (wr_idx == REG_IDX_LAUNCH);
    assign launch_ok     = launch_req && !tx_busy;
    assign launch_reject = launch_req && tx_busy;
    // A refused launch must also leave REG3 untouched
    assign reg_we        = wr_fire && !launch_reject;

    assign wr_old = regs_reg[wr_idx];

    // Byte-lane merge of the new write data with the current register value
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
`ifdef KTH_NOC_AXIL_WSTRB_EN
            assign wr_word[gi*8 +: 8] = s_axi.S_AXI_WSTRB[gi] ? s_axi.S_AXI_WDATA[gi*8 +: 8]
                                                              : wr_old[gi*8 +: 8];
`else
            assign wr_word[gi*8 +: 8] = s_axi.S_AXI_WDATA[gi*8 +: 8];
`endif
        end
    endgenerate

    // Accept pulse: one cycle high, only when no response is outstanding
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_accept_reg <= 1'b0;
        end else begin
            wr_accept_reg <= !wr_accept_reg && !bvalid_reg &&
                             s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            bvalid_reg <= 1'b0;
            bresp_reg  <= RESP_OKAY;
        end else if (wr_fire) begin
            bvalid_reg <= 1'b1;
            bresp_reg  <= launch_reject ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_reg && s_axi.S_AXI_BREADY) begin
            bvalid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (reg_we) begin
            regs_reg[wr_idx] <= wr_word;
        end
    end

    assign s_axi.S_AXI_AWREADY = wr_accept_reg;
    assign s_axi.S_AXI_WREADY  = wr_accept_reg;
    assign s_axi.S_AXI_BVALID  = bvalid_reg;
    assign s_axi.S_AXI_BRESP   = bresp_reg;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic                          arready_reg;
    logic                          rvalid_reg;
    logic [DW-1:0]                 rdata_reg;
    logic [C_S_AXI_ADDR_WIDTH-1:0] ar_addr;
    reg_idx_t                      rd_idx;
    logic                          rd_fire;

    assign ar_addr = s_axi.S_AXI_ARADDR;
    assign rd_idx  = ar_addr[3:2];
    assign rd_fire = arready_reg && s_axi.S_AXI_ARVALID;

    always_ff @(posedge clk) begin
        if (srst) begin
            arready_reg <= 1'b0;
        end else begin
            arready_reg <= !arready_reg && !rvalid_reg && s_axi.S_AXI_ARVALID;
        end
    end

    // rdata samples the register array before any same-edge write lands,
    // so a collision with a write returns the old value
    always_ff @(posedge clk) begin
        if (srst) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else if (rd_fire) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= regs_reg[rd_idx];
        end else if (rvalid_reg && s_axi.S_AXI_RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end

    assign s_axi.S_AXI_ARREADY = arready_reg;
    assign s_axi.S_AXI_RVALID  = rvalid_reg;
    assign s_axi.S_AXI_RDATA   = rdata_reg;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;

    // ------------------------------------------------------------------
    // Flit launch. The launch write targets REG3 only, so DATA0/DEST as
    // currently stored are already the post-write values.
    // ------------------------------------------------------------------
    kth_noc_axil_tx_launch #(
        .DATA_W (DW),
        .DEST_W (DEST_W)
    ) u_tx_launch (
        .clk      (clk),
        .srst     (srst),
        .launch_i (launch_ok),
        .flit_i   (regs_reg[REG_IDX_DATA0]),
        .dest_i   (regs_reg[REG_IDX_DEST][DEST_W-1:0]),
        .ready_i  (tx_ready_i),
        .flit_o   (tx_flit_o),
        .dest_o   (tx_dest_o),
        .valid_o  (tx_valid_o),
        .busy_o   (tx_busy)
    );

    // Protection bits and the sub-word address bits carry no meaning here
    logic unused_sink;
`ifdef KTH_NOC_AXIL_WSTRB_EN
    assign unused_sink = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           aw_addr[1:0], ar_addr[1:0]};
`else
    assign unused_sink = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           aw_addr[1:0], ar_addr[1:0],
                           s_axi.S_AXI_WSTRB, wr_old};
`endif

endmodule : kth_noc_axil_slave

// File: tb/tb_kth_noc_axil_slave.sv
// -----------------------------------------------------------------------------
// tb_kth_noc_axil_slave
// Directed self-checking bench for kth_noc_axil_slave. Expected values are
// hand-computed constants. Honours KTH_NOC_AXIL_WSTRB_EN for the strobe case.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_kth_noc_axil_slave;

    logic        tb_ACLK;
    logic        tb_ARESET;
    logic [31:0] tx_flit;
    logic [1:0]  tx_dest;
    logic        tx_valid;
    logic        tx_ready;

    int n_vec;
    int n_err;

    kth_noc_axil_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) axi_if ();

    kth_noc_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .DEST_W             (2)
    ) dut (
        .S_AXI_ACLK   (tb_ACLK),
        .S_AXI_ARESET (tb_ARESET),
        .s_axi        (axi_if.slave),
        .tx_flit_o    (tx_flit),
        .tx_dest_o    (tx_dest),
        .tx_valid_o   (tx_valid),
        .tx_ready_i   (tx_ready)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Full write transaction. With hold_b=1 it returns while BVALID is still
    // pending (BREADY held low).
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit hold_b,
                             output logic [1:0] resp);
        bit seen;
        axi_if.S_AXI_BREADY = !hold_b;
        @(posedge tb_ACLK); #1;
        axi_if.S_AXI_AWADDR  = addr;
        axi_if.S_AXI_WDATA   = data;
        axi_if.S_AXI_WSTRB   = strb;
        axi_if.S_AXI_AWVALID = 1'b1;
        axi_if.S_AXI_WVALID  = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge tb_ACLK); #1;
            if (axi_if.S_AXI_AWREADY && axi_if.S_AXI_WREADY) seen = 1'b1;
        end
        check("wr_addr_handshake", 32'(seen), 32'd1);
        @(posedge tb_ACLK); #1;
        axi_if.S_AXI_AWVALID = 1'b0;
        axi_if.S_AXI_WVALID  = 1'b0;
        seen = 1'b0;
        resp = 2'bxx;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (axi_if.S_AXI_BVALID) begin
                seen = 1'b1;
                resp = axi_if.S_AXI_BRESP;
            end else begin
                @(posedge tb_ACLK); #1;
            end
        end
        check("wr_bvalid_seen", 32'(seen), 32'd1);
        if (!hold_b) begin
            @(posedge tb_ACLK); #1;
        end
        $display("WR addr=0x%1h data=0x%08h strb=%4b bresp=%2b", addr, data, strb, resp);
    endtask

    // Full read transaction. With hold_r=1 it returns while RVALID is still
    // pending (RREADY held low).
    task automatic axi_read(input logic [3:0] addr, input bit hold_r,
                            output logic [31:0] data, output logic [1:0] resp);
        bit seen;
        axi_if.S_AXI_RREADY = !hold_r;
        @(posedge tb_ACLK); #1;
        axi_if.S_AXI_ARADDR  = addr;
        axi_if.S_AXI_ARVALID = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge tb_ACLK); #1;
            if (axi_if.S_AXI_ARREADY) seen = 1'b1;
        end
        check("rd_addr_handshake", 32'(seen), 32'd1);
        @(posedge tb_ACLK); #1;
        axi_if.S_AXI_ARVALID = 1'b0;
        seen = 1'b0;
        data = 'x;
        resp = 2'bxx;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (axi_if.S_AXI_RVALID) begin
                seen = 1'b1;
                data = axi_if.S_AXI_RDATA;
                resp = axi_if.S_AXI_RRESP;
            end else begin
                @(posedge tb_ACLK); #1;
            end
        end
        check("rd_rvalid_seen", 32'(seen), 32'd1);
        if (!hold_r) begin
            @(posedge tb_ACLK); #1;
        end
        $display("RD addr=0x%1h data=0x%08h rresp=%2b", addr, data, resp);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] exp_user;

        n_vec = 0;
        n_err = 0;
        tb_ARESET = 1'b1;
        tx_ready  = 1'b0;
        axi_if.S_AXI_AWADDR  = '0;
        axi_if.S_AXI_AWPROT  = '0;
        axi_if.S_AXI_AWVALID = 1'b0;
        axi_if.S_AXI_WDATA   = '0;
        axi_if.S_AXI_WSTRB   = 4'hF;
        axi_if.S_AXI_WVALID  = 1'b0;
        axi_if.S_AXI_BREADY  = 1'b1;
        axi_if.S_AXI_ARADDR  = '0;
        axi_if.S_AXI_ARPROT  = '0;
        axi_if.S_AXI_ARVALID = 1'b0;
        axi_if.S_AXI_RREADY  = 1'b1;
        repeat (3) @(posedge tb_ACLK);
        #1 tb_ARESET = 1'b0;

        // Reset state
        check("rst_awready", 32'(axi_if.S_AXI_AWREADY), 32'd0);
        check("rst_wready",  32'(axi_if.S_AXI_WREADY),  32'd0);
        check("rst_bvalid",  32'(axi_if.S_AXI_BVALID),  32'd0);
        check("rst_bresp",   32'(axi_if.S_AXI_BRESP),   32'd0);
        check("rst_arready", 32'(axi_if.S_AXI_ARREADY), 32'd0);
        check("rst_rvalid",  32'(axi_if.S_AXI_RVALID),  32'd0);
        check("rst_rdata",   axi_if.S_AXI_RDATA,        32'd0);
        check("rst_rresp",   32'(axi_if.S_AXI_RRESP),   32'd0);
        check("rst_txvalid", 32'(tx_valid),             32'd0);

        // 1: plain register writes and readback
        axi_write(4'h0, 32'h0101FFFF, 4'hF, 1'b0, resp); check("t1_bresp0", 32'(resp), 32'd0);
        axi_write(4'h4, 32'hABCD0001, 4'hF, 1'b0, resp); check("t1_bresp4", 32'(resp), 32'd0);
        axi_write(4'h8, 32'hDEAD0011, 4'hF, 1'b0, resp); check("t1_bresp8", 32'(resp), 32'd0);
        axi_read(4'h0, 1'b0, rdata, resp); check("t1_rd0", rdata, 32'h0101FFFF); check("t1_rresp", 32'(resp), 32'd0);
        axi_read(4'h4, 1'b0, rdata, resp); check("t1_rd4", rdata, 32'hABCD0001);
        axi_read(4'h8, 1'b0, rdata, resp); check("t1_rd8", rdata, 32'hDEAD0011);

        // 2: launch with router stalled
        axi_write(4'hC, 32'hBEEF0011, 4'hF, 1'b0, resp); check("t2_bresp", 32'(resp), 32'd0);
        check("t2_txvalid", 32'(tx_valid), 32'd1);
        check("t2_txflit",  tx_flit,       32'h0101FFFF);
        check("t2_txdest",  32'(tx_dest),  32'd1);
        axi_read(4'hC, 1'b0, rdata, resp); check("t2_rdC", rdata, 32'hBEEF0011);

        // 3: busy launch refused; payload writes do not disturb captured flit
        axi_write(4'hC, 32'h12345678, 4'hF, 1'b0, resp); check("t3_bresp_slverr", 32'(resp), 32'd2);
        axi_read(4'hC, 1'b0, rdata, resp); check("t3_rdC_kept", rdata, 32'hBEEF0011);
        axi_write(4'h0, 32'h22223333, 4'hF, 1'b0, resp); check("t3_bresp_data0", 32'(resp), 32'd0);
        check("t3_txflit_held", tx_flit, 32'h0101FFFF);
        check("t3_txvalid_held", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        @(posedge tb_ACLK); #1;
        tx_ready = 1'b0;
        check("t3_txvalid_clr", 32'(tx_valid), 32'd0);

        // 4: BREADY held low blocks further writes
        axi_write(4'h4, 32'h00000002, 4'hF, 1'b1, resp); check("t4_bresp", 32'(resp), 32'd0);
        axi_if.S_AXI_AWADDR  = 4'h8;
        axi_if.S_AXI_WDATA   = 32'h55555555;
        axi_if.S_AXI_WSTRB   = 4'hF;
        axi_if.S_AXI_AWVALID = 1'b1;
        axi_if.S_AXI_WVALID  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge tb_ACLK); #1;
            check("t4_bvalid_hold", 32'(axi_if.S_AXI_BVALID), 32'd1);
            check("t4_awready_low", 32'(axi_if.S_AXI_AWREADY), 32'd0);
        end
        axi_if.S_AXI_AWVALID = 1'b0;
        axi_if.S_AXI_WVALID  = 1'b0;
        axi_if.S_AXI_BREADY  = 1'b1;
        @(posedge tb_ACLK); #1;
        check("t4_bvalid_clr", 32'(axi_if.S_AXI_BVALID), 32'd0);
        axi_read(4'h4, 1'b0, rdata, resp); check("t4_rd4", rdata, 32'h00000002);
        axi_read(4'h8, 1'b0, rdata, resp); check("t4_rd8_untouched", rdata, 32'hDEAD0011);
        axi_write(4'h0, 32'h0101FFFF, 4'hF, 1'b0, resp); check("t4_next_write", 32'(resp), 32'd0);
        axi_read(4'h0, 1'b0, rdata, resp); check("t4_rd0", rdata, 32'h0101FFFF);

        // 5: partial strobe
`ifdef KTH_NOC_AXIL_WSTRB_EN
        exp_user = 32'hDEAD5555;
`else
        exp_user = 32'hAAAA5555;
`endif
        axi_write(4'h8, 32'hAAAA5555, 4'b0011, 1'b0, resp); check("t5_bresp", 32'(resp), 32'd0);
        axi_read(4'h8, 1'b0, rdata, resp); check("t5_rd8_strb", rdata, exp_user);

        // 6: reset with read response and flit both pending
        axi_write(4'hC, 32'hCAFEF00D, 4'hF, 1'b0, resp); check("t6_bresp", 32'(resp), 32'd0);
        check("t6_txvalid", 32'(tx_valid), 32'd1);
        check("t6_txflit",  tx_flit,       32'h0101FFFF);
        check("t6_txdest",  32'(tx_dest),  32'd2);
        axi_read(4'h0, 1'b1, rdata, resp); check("t6_rd0_pending", rdata, 32'h0101FFFF);
        check("t6_rvalid_pre", 32'(axi_if.S_AXI_RVALID), 32'd1);
        tb_ARESET = 1'b1;
        @(posedge tb_ACLK); #1;
        tb_ARESET = 1'b0;
        check("t6_rvalid_rst",  32'(axi_if.S_AXI_RVALID),  32'd0);
        check("t6_bvalid_rst",  32'(axi_if.S_AXI_BVALID),  32'd0);
        check("t6_txvalid_rst", 32'(tx_valid),             32'd0);
        check("t6_arready_rst", 32'(axi_if.S_AXI_ARREADY), 32'd0);
        axi_if.S_AXI_RREADY = 1'b1;
        axi_read(4'h0, 1'b0, rdata, resp); check("t6_rd0_zero", rdata, 32'd0);
        axi_read(4'h4, 1'b0, rdata, resp); check("t6_rd4_zero", rdata, 32'd0);
        axi_read(4'h8, 1'b0, rdata, resp); check("t6_rd8_zero", rdata, 32'd0);
        axi_read(4'hC, 1'b0, rdata, resp); check("t6_rdC_zero", rdata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_kth_noc_axil_slave
